// File: rtl/spi_flash_read_arb_pkg.sv
// Shared constants and types for the two-port SPI flash read arbiter.
// Imported by the shifter and the top level.
package spi_flash_read_arb_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam logic [7:0] SPI_CMD_WAKE = 8'hAB;

  localparam logic [6:0] LEN_WAKE = 7'd8;
  localparam logic [6:0] LEN_READ = 7'd64;

  typedef enum logic [2:0] {
    INIT,
    INIT_SHIFT,
    GAP,
    IDLE,
    SHIFT
  } state_e;

  // Flash returns bytes MSB-first in address order; the word is little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_read_arb_shifter.sv
// Mode-0 SPI bit engine: clock divider, 64-bit shift register, bit counter.
// done_o is combinational and marks the last cycle of the final high half.
module spi_bit_shifter
  import spi_flash_read_arb_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [6:0]  len_i,
  input  logic [63:0] word_i,
  input  logic        miso_i,
  output logic        flash_clk_o,
  output logic        flash_io0_o,
  output logic [31:0] rx_o,
  output logic        done_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);

  logic          active_q;
  logic          phase_q;
  logic [DW-1:0] div_q;
  logic [5:0]    bit_q;
  logic [6:0]    len_q;
  logic [63:0]   sh_q;
  logic          sclk_q;
  logic          io0_q;
  logic [31:0]   rx_q;
  logic          tick;

  assign tick   = active_q && (div_q == DIV_END);
  assign done_o = tick && phase_q &&
                  ({1'b0, bit_q} == (len_q - 7'd1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      len_q    <= LEN_READ;
      sh_q     <= '0;
      sclk_q   <= 1'b0;
      io0_q    <= 1'b0;
      rx_q     <= '0;
    end else if (start_i && !active_q) begin
      active_q <= 1'b1;
      phase_q  <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      len_q    <= len_i;
      sh_q     <= word_i;
      sclk_q   <= 1'b0;
      io0_q    <= word_i[63];
    end else if (active_q) begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick && !phase_q) begin
        // Rising edge: MISO has been stable for the whole low half.
        phase_q <= 1'b1;
        sclk_q  <= 1'b1;
        rx_q    <= {rx_q[30:0], miso_i};
      end else if (done_o) begin
        active_q <= 1'b0;
        sclk_q   <= 1'b0;
        io0_q    <= 1'b0;
      end else if (tick) begin
        phase_q <= 1'b0;
        sclk_q  <= 1'b0;
        bit_q   <= bit_q + 6'd1;
        sh_q    <= {sh_q[62:0], 1'b0};
        io0_q   <= sh_q[62];
      end
    end
  end

  assign flash_clk_o = sclk_q;
  assign flash_io0_o = io0_q;
  assign rx_o        = rx_q;

endmodule

// File: rtl/spi_flash_read_arb.sv
// Two-port round-robin word reader for a single-bit SPI flash.
// Wakes the flash with 0xAB once after reset, then serves 0x03 reads.
module spi_flash_read_arb
  import spi_flash_read_arb_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CSB_GAP = 2
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        req0,
  input  logic [23:0] addr0,
  input  logic        req1,
  input  logic [23:0] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam int GW = (CSB_GAP > 1) ? $clog2(CSB_GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'(CSB_GAP - 1);

  state_e        state_q;
  logic          ptr_q;
  logic          grant_q;
  logic          ready_q;
  logic          busy_q;
  logic          csb_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [31:0]   rdata_q;
  logic [GW-1:0] gap_q;

  logic          gnt1_c;
  logic          start_c;
  logic [6:0]    len_c;
  logic [63:0]   word_c;
  logic [31:0]   sh_rx;
  logic          sh_done;

  // ptr_q names the port that wins a tie.
  always_comb begin
    gnt1_c = 1'b0;
    unique case (1'b1)
      req0 & req1:  gnt1_c = ptr_q;
      req1 & ~req0: gnt1_c = 1'b1;
      default:      gnt1_c = 1'b0;
    endcase
  end

  always_comb begin
    start_c = 1'b0;
    len_c   = LEN_READ;
    word_c  = {SPI_CMD_READ, gnt1_c ? addr1 : addr0, 32'h0};
    unique case (state_q)
      INIT: begin
        start_c = 1'b1;
        len_c   = LEN_WAKE;
        word_c  = {SPI_CMD_WAKE, 56'h0};
      end
      IDLE:    start_c = req0 | req1;
      default: start_c = 1'b0;
    endcase
  end

  spi_bit_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk_i      (clock),
    .rst_ni     (resetb),
    .start_i    (start_c),
    .len_i      (len_c),
    .word_i     (word_c),
    .miso_i     (flash_io1),
    .flash_clk_o(flash_clk),
    .flash_io0_o(flash_io0),
    .rx_o       (sh_rx),
    .done_o     (sh_done)
  );

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q <= INIT;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      csb_q   <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
      gap_q   <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          csb_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= INIT_SHIFT;
        end
        INIT_SHIFT: begin
          if (sh_done) begin
            csb_q   <= 1'b1;
            gap_q   <= GAP_INIT;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        IDLE: begin
          if (req0 | req1) begin
            grant_q <= gnt1_c;
            ptr_q   <= ~gnt1_c;
            csb_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (sh_done) begin
            csb_q   <= 1'b1;
            ack0_q  <= ~grant_q;
            ack1_q  <= grant_q;
            rdata_q <= bswap32(sh_rx);
            gap_q   <= GAP_INIT;
            state_q <= GAP;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign flash_csb = csb_q;

endmodule

// File: doc/spi_flash_read_arb.md
Name: spi_flash_read_arb

Overview:
- Read-only single-bit SPI flash controller that shares one user-area flash (on the mprj_io flash pins, opcode 0x03 READ) between two word-read requesters, e.g. Microwatt fetch and a boot loader/DMA.
- After reset it sends the release-power-down command (0xAB) once, which the flash model requires before it accepts reads.
- After that it serves 32-bit reads with round-robin arbitration.

Parameters:
- CLK_DIV, 1: SPI half-period in clock cycles (>=1); one SPI bit = 2*CLK_DIV cycles.
- CSB_GAP, 2: minimum cycles flash_csb stays high between transactions (>=1).

Ports:
- clock  in  1  system clock
- resetb  in  1  synchronous active-low reset
- req0  in  1  requester 0 read request; held high until ack0
- addr0  in  24  requester 0 byte address; stable while req0 high
- req1  in  1  requester 1 read request
- addr1  in  24  requester 1 byte address
- ack0  out  1  one-cycle completion pulse, requester 0
- ack1  out  1  one-cycle completion pulse, requester 1
- rdata  out  32  read word; valid in the ack cycle, held until the next ack
- ready  out  1  high once the 0xAB init sequence has completed
- busy  out  1  high while flash_csb is low or the gap is running
- flash_csb  out  1  chip select, active low
- flash_clk  out  1  SPI clock, mode 0 (idles low)
- flash_io0  out  1  MOSI
- flash_io1  in  1  MISO

Behaviour:
Reset (clock edge with resetb=0):
- Outputs: flash_csb=1, flash_clk=0, flash_io0=0, ack0=ack1=0, rdata=0, ready=0, busy=0.
- Round-robin pointer favours port 0.
- FSM goes to INIT.
- A reset asserted mid-transfer takes effect on that edge: csb high, no ack, partial data discarded.

FSM states: INIT -> INIT_SHIFT -> GAP -> IDLE -> SHIFT -> GAP -> IDLE.
- INIT: drive csb low and shift opcode 0xAB (8 bits), then GAP. Leaving that first GAP sets ready=1 permanently.
- IDLE arbitration, in the cycle both requests are sampled:
  - Only one req high: grant it.
  - Both high: grant the port not served last.
  - The pointer updates on grant.
- IDLE -> SHIFT: on the next cycle csb=0 and io0 carries bit 63 of the shift word {8'h03, addr, 32'h0}, MSB first.
- Each bit lasts 2*CLK_DIV cycles:
  - flash_clk low for the first CLK_DIV cycles, high for the next CLK_DIV.
  - io0 changes only when flash_clk is low.
  - io1 is sampled on the cycle flash_clk rises.
- Bit counter runs 0..63; bits 32..63 are data.
- Data bytes arrive MSB first. rdata is little-endian: rdata[7:0] = byte at addr, [15:8] = addr+1, [23:16] = addr+2, [31:24] = addr+3.
- After the high half of bit 63:
  - flash_clk=0, flash_csb=1.
  - Granted ack pulses for one cycle and rdata updates in that same cycle.
  - FSM enters GAP.
- GAP lasts CSB_GAP cycles including the ack cycle, then IDLE. Requests are not granted during GAP.
- Latency: req sampled in IDLE at cycle 0 -> csb low at cycle 1 -> ack at cycle 1+128*CLK_DIV (129 for CLK_DIV=1).
- The next csb-low is no earlier than cycle 1+128*CLK_DIV+CSB_GAP.
- Addresses wrap modulo 2^24 in the flash; the controller does no checks.
- A req dropped mid-transfer is a protocol violation: the transfer completes and ack still pulses.
- Requests before ready are held pending; none are lost.
- ack0 and ack1 are never high together.

Decomposition:
- Shared package constants: SPI_CMD_READ=8'h03, SPI_CMD_WAKE=8'hAB, and the state enum (INIT, INIT_SHIFT, GAP, IDLE, SHIFT).
- One natural sub-module, spi_bit_shifter:
  - Owns the clock divider, the 64-bit shift register and the bit counter.
  - Inputs: start and length (8 or 64).
  - Outputs: flash_clk, flash_io0, the sampled shift-in word and done.
- The top level holds the arbiter, pointer, ready, gap counter and ack/rdata.

Test Plan:
- Reset release, CLK_DIV=1:
  - csb low at cycle 1, io0 shows 1010_1011 over 8 bits.
  - csb high after 16 cycles; ready=1 after CSB_GAP more cycles.
  - Flash model reports powered up.
- req0, addr0=0x000010, flash bytes 11 22 33 44 -> ack0 129 cycles after grant, rdata=0x44332211, io0 sequence 0x03,0x00,0x00,0x10.
- req0 and req1 high in the same cycle after reset -> port 0 served first, then port 1 after the gap. Both held continuously -> ack0, ack1, ack0... alternate; never both high.
- CLK_DIV=4, CSB_GAP=3, req1 addr 0xFFFFFC -> ack1 at cycle 513, flash_clk period 8 cycles, back-to-back csb-high gap >=3 cycles.
- resetb low during data bit 40 -> next edge csb=1, flash_clk=0, no ack. INIT 0xAB resends; a pending req completes afterwards with correct data.
- req1 raised before ready -> granted on the first IDLE cycle after ready, with correct rdata.
